// File: rtl/fsm_state_pkg.sv
// Shared constants and helpers for the FSM state register and its dwell counter.
// Pure definitions: no latency, no flow control.
package fsm_state_pkg;

  localparam int STATE_W_DEFAULT = 4;
  localparam int DWELL_W_DEFAULT = 8;

  // All-ones value of the given width, clamped to 32 bits.
  function automatic logic [31:0] sat_max(input int width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating cycle counter with sync clear and registered saturation flag.
// 1-clock latency on count and sat; always counts, no backpressure.
module dwell_counter
  import fsm_state_pkg::*;
#(
  parameter int W = DWELL_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clear)              count_d = '0;
    else if (count != MAX)  count_d = count + W'(1);
  end

  // sat tracks the value being written so both outputs move on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_d;
      sat   <= (count_d == MAX);
    end
  end

endmodule

// File: rtl/fsm_state_flop.sv
// Single state bit flip-flop with a per-bit async reset value.
// 1-clock latency, always loads d; no backpressure.
module fsm_state_flop #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= RST_VAL;
    else          q <= d;
  end

endmodule

// File: rtl/fsm_state_reg.sv
// FSM state register with force-load, change tracking, dwell count; STATE_LEGAL_CHECK_EN adds illegal-encoding recovery.
// 1-clock load latency, all outputs registered; accepts every cycle, no backpressure.
module fsm_state_reg
  import fsm_state_pkg::*;
#(
  parameter int STATE_W     = STATE_W_DEFAULT,
  parameter int NUM_STATES  = 16,
  parameter int RESET_STATE = 0,
  parameter int SAFE_STATE  = 0,
  parameter int DWELL_W     = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [STATE_W-1:0] next_state,
  input  logic               force_valid,
  input  logic [STATE_W-1:0] force_state,
  output logic [STATE_W-1:0] current_state,
  output logic [STATE_W-1:0] prev_state,
  output logic               state_changed,
  output logic [DWELL_W-1:0] dwell_count,
  output logic               dwell_sat,
  output logic               illegal
);

  if (STATE_W < 1 || STATE_W > 16) begin : g_bad_state_w
    $error("fsm_state_reg: STATE_W out of range");
  end
  if (DWELL_W < 2 || DWELL_W > 32) begin : g_bad_dwell_w
    $error("fsm_state_reg: DWELL_W out of range");
  end
  if (NUM_STATES < 2 || NUM_STATES > (1 << STATE_W)) begin : g_bad_num
    $error("fsm_state_reg: NUM_STATES out of range");
  end
  if (RESET_STATE < 0 || RESET_STATE >= NUM_STATES) begin : g_bad_reset
    $error("fsm_state_reg: RESET_STATE not a legal encoding");
  end
  if (SAFE_STATE < 0 || SAFE_STATE >= NUM_STATES) begin : g_bad_safe
    $error("fsm_state_reg: SAFE_STATE not a legal encoding");
  end

  localparam logic [STATE_W-1:0] RESET_V = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] cand;
  logic [STATE_W-1:0] commit;
  logic [STATE_W-1:0] cur_q;
  logic               bad;
  logic               changed;

  always_comb begin
    cand = cur_q;
    if (force_valid) cand = force_state;
    else if (en)     cand = next_state;
  end

`ifdef STATE_LEGAL_CHECK_EN
  localparam logic [STATE_W-1:0] SAFE_V = STATE_W'(SAFE_STATE);
  // Only freshly loaded values are checked; a held value is already legal.
  assign bad    = (force_valid | en) && (32'(cand) >= NUM_STATES);
  assign commit = bad ? SAFE_V : cand;
`else
  assign bad    = 1'b0;
  assign commit = cand;
`endif

  for (genvar i = 0; i < STATE_W; i++) begin : g_state_bit
    fsm_state_flop #(.RST_VAL(RESET_V[i])) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (commit[i]),
      .q       (cur_q[i])
    );
  end

  assign changed = (commit != cur_q);

  logic [STATE_W-1:0] prev_q;
  logic               changed_q;
  logic               illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= RESET_V;
      changed_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (changed) prev_q <= cur_q;
      changed_q <= changed;
      illegal_q <= bad;
    end
  end

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (changed),
    .count   (dwell_count),
    .sat     (dwell_sat)
  );

  assign current_state = cur_q;
  assign prev_state    = prev_q;
  assign state_changed = changed_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_fsm_state_reg.sv
// Scoreboard bench for fsm_state_reg: directed scenarios then random loads, checked against a behavioural model.
module tb_fsm_state_reg;

  localparam int STATE_W = 4;
  localparam int NUM     = 10;
  localparam int RST_ST  = 3;
  localparam int SAFE    = 0;
  localparam int DW      = 3;
  localparam int DMAX    = (1 << DW) - 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               en = 1'b0;
  logic [STATE_W-1:0] next_state = '0;
  logic               force_valid = 1'b0;
  logic [STATE_W-1:0] force_state = '0;
  logic [STATE_W-1:0] current_state;
  logic [STATE_W-1:0] prev_state;
  logic               state_changed;
  logic [DW-1:0]      dwell_count;
  logic               dwell_sat;
  logic               illegal;

  fsm_state_reg #(
    .STATE_W(STATE_W), .NUM_STATES(NUM), .RESET_STATE(RST_ST),
    .SAFE_STATE(SAFE), .DWELL_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .next_state(next_state),
    .force_valid(force_valid), .force_state(force_state),
    .current_state(current_state), .prev_state(prev_state),
    .state_changed(state_changed), .dwell_count(dwell_count),
    .dwell_sat(dwell_sat), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cur;
    int prev;
    int chg;
    int dw;
    int sat;
    int ill;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  int m_cur = RST_ST, m_prev = RST_ST, m_dw = 0, m_chg = 0, m_ill = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = RST_ST; m_prev = RST_ST; m_dw = 0; m_chg = 0; m_ill = 0;
  endtask

  // Reference behaviour of one clock edge, straight from the load/change/dwell rules.
  task automatic model_edge(input bit rst, input bit fv, input int fs, input bit e, input int ns);
    int l;
    bit ld;
    if (!rst) begin
      model_reset();
      return;
    end
    ld = fv | e;
    l  = fv ? fs : (e ? ns : m_cur);
    m_ill = 0;
`ifdef STATE_LEGAL_CHECK_EN
    if (ld && l >= NUM) begin
      l = SAFE;
      m_ill = 1;
    end
`endif
    if (l != m_cur) begin
      m_prev = m_cur;
      m_cur  = l;
      m_chg  = 1;
      m_dw   = 0;
    end else begin
      m_chg = 0;
      if (m_dw < DMAX) m_dw++;
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.cur = m_cur; x.prev = m_prev; x.chg = m_chg; x.dw = m_dw;
    x.sat = (m_dw == DMAX) ? 1 : 0; x.ill = m_ill;
    sb.push_back(x);
  endtask

  task automatic cycle(input bit rst, input bit fv, input int fs, input bit e, input int ns);
    @(negedge clk); #1;
    reset_n = rst; force_valid = fv; force_state = STATE_W'(fs);
    en = e; next_state = STATE_W'(ns);
    @(posedge clk); #1;
    model_edge(rst, fv, fs, e, ns);
    push_exp();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  // Edge happens, then reset drops between edges; the check sees reset values before the next edge.
  task automatic cycle_mid_reset();
    @(negedge clk); #1;
    reset_n = 1; force_valid = 0; en = 0;
    @(posedge clk); #1;
    model_edge(1, 0, 0, 0, 0);
    reset_n = 0;
    #1;
    model_reset();
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("current_state", int'(current_state), e.cur);
        chk("prev_state",    int'(prev_state),    e.prev);
        chk("state_changed", int'(state_changed), e.chg);
        chk("dwell_count",   int'(dwell_count),   e.dw);
        chk("dwell_sat",     int'(dwell_sat),     e.sat);
        chk("illegal",       int'(illegal),       e.ill);
      end
    end
  end

  initial begin : stim
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    hold(5);                    // reset state held, dwell 1..5
    cycle(1, 0, 0, 1, 7);       // change to 7
    hold(10);                   // dwell climbs and saturates
    cycle(1, 1, 9, 1, 2);       // force beats en
    hold(2);
    cycle(1, 0, 0, 1, 9);       // reload same value: no change
    cycle(1, 0, 0, 1, 5);
    cycle(1, 0, 0, 1, 12);      // out-of-range next_state
    cycle(1, 0, 0, 1, 5);
    cycle(1, 1, 15, 0, 0);      // out-of-range force_state
    cycle(1, 0, 0, 1, 0);
    hold(1);
    cycle(1, 0, 0, 1, 11);      // recovery equals current state
    cycle(1, 0, 0, 1, 6);
    hold(3);
    cycle_mid_reset();          // dwell reaches 4 on this edge, then reset
    cycle(0, 0, 0, 1, 8);
    cycle(1, 0, 0, 1, 8);       // first edge after release loads normally
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)));
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_state_reg.md
# fsm_state_reg

Parametrised FSM state register: the successor to the fixed 4-bit state flop bank. It holds the current state of a controller FSM and adds several features: load enable, priority force-load, change tracking, a saturating dwell counter and optional illegal-encoding recovery. It sits between a controller's combinational next-state logic and everything that decodes the current state.

## Interface
- STATE_W, 4, state encoding width in bits (1..16)
- NUM_STATES, 16, number of legal encodings, 0..NUM_STATES-1 (2..2^STATE_W)
- RESET_STATE, 0, value loaded by reset
- SAFE_STATE, 0, recovery value for illegal encodings (< NUM_STATES)
- DWELL_W, 8, dwell counter width (2..32)

Ports:
- clk  in  1  rising-edge clock; one clock only
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  load next_state on this edge
- next_state  in  STATE_W  candidate state from next-state logic
- force_valid  in  1  override load, priority over en
- force_state  in  STATE_W  override value
- current_state  out  STATE_W  registered state
- prev_state  out  STATE_W  state held before the most recent change
- state_changed  out  1  one-cycle pulse, state differs from previous cycle
- dwell_count  out  DWELL_W  cycles since last change, saturating
- dwell_sat  out  1  dwell_count at all-ones
- illegal  out  1  one-cycle pulse, illegal encoding was replaced by SAFE_STATE

## Operation
- While reset_n is low:
  - current_state = prev_state = RESET_STATE.
  - state_changed = 0, dwell_count = 0, dwell_sat = 0, illegal = 0.
- Candidate L on each edge:
  - force_valid → force_state;
  - else en → next_state;
  - else current_state (hold).
- Legal check (macro enabled): if L ≥ NUM_STATES, SAFE_STATE is committed instead and illegal = 1 for the following cycle. A held value is never re-checked.
- Change: committed value ≠ current_state:
  - prev_state ← old current_state;
  - state_changed = 1 for one cycle;
  - dwell_count ← 0.
- No change, including reloading the same value:
  - prev_state holds;
  - state_changed = 0;
  - dwell_count increments, saturates at 2^DWELL_W−1, never wraps.
- dwell_sat is registered alongside dwell_count and is high iff dwell_count is all-ones.
- Simultaneous force_valid and en: force wins and next_state is ignored.
- Illegal force_state is recovered to SAFE_STATE exactly like an illegal next_state.
- Illegal value whose recovery equals current_state:
  - illegal pulses;
  - state_changed = 0;
  - dwell continues counting.

## Timing
- Load latency: 1 clock. All outputs are registered and update together on the same edge.
- Reset assertion is asynchronous and mid-operation: outputs take reset values immediately, and the dwell count is lost.
- Reset deassertion: the first edge with reset_n high performs a normal load.
- No combinational path from any input to any output.

## Configuration
- STATE_LEGAL_CHECK_EN defined:
  - comparator against NUM_STATES plus SAFE_STATE substitution;
  - illegal pulse as described.
- STATE_LEGAL_CHECK_EN not defined:
  - every STATE_W-bit value is committed verbatim;
  - illegal is tied to 0;
  - SAFE_STATE is unused;
  - NUM_STATES is used only for the parameter range check.

## Structure
- Package fsm_state_pkg holds:
  - default width constants (STATE_W_DEFAULT, DWELL_W_DEFAULT);
  - the saturating-max helper function, all-ones of a given width.
- Elaboration check: NUM_STATES ≤ 2^STATE_W, RESET_STATE < NUM_STATES, SAFE_STATE < NUM_STATES; elaboration fails otherwise.
- Sub-module: dwell_counter (saturating counter with sync clear, async reset, sat flag).
- State bits are a generate loop of the existing flipflop cell, with the load mux in front of d.

## Test plan
- Reset/enable: reset with RESET_STATE=3, release, en=0 for 5 cycles:
  - current_state=3 throughout;
  - state_changed never asserts;
  - dwell_count reaches 5.
- Change and dwell: next_state=7, en=1 for one edge, then hold for 10 cycles:
  - current_state=7 one cycle later, prev_state=3, state_changed pulses once;
  - dwell_count 0,1,…,10.
- Force priority: en=1/next_state=2 together with force_valid=1/force_state=9:
  - current_state=9;
  - then reload 9 via en → state_changed=0, dwell not cleared.
- Saturation: DWELL_W=3, hold for 12 cycles:
  - dwell_count stops at 7;
  - dwell_sat=1 from the cycle dwell reaches 7.
- Illegal recovery (macro on, NUM_STATES=10, SAFE_STATE=0, from state 5): next_state=12, en=1:
  - current_state=0, illegal=1 one cycle, prev_state=5;
  - with macro off the same stimulus yields current_state=12, illegal=0.
- Async reset mid-dwell: assert reset_n low between edges at dwell_count=4:
  - outputs return to reset values before the next edge.
